// File: rtl/ifetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: boolean literals,
// RISC-V opcodes used by next-PC prediction, reset PC default, BHT counter
// geometry, and immediate-decoding helpers.
package ifetch_unit_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam int          BHT_CNT_W    = 2;
  localparam logic [1:0]  BHT_CNT_INIT = 2'b01;  // weakly not-taken

  // J-type immediate, sign-extended, bit 0 forced to zero.
  function automatic logic [31:0] jal_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended, bit 0 forced to zero.
  function automatic logic [31:0] br_imm(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_unit_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters, one lookup
// port and one update port. A lookup of the entry being updated in the same
// cycle returns the old value (registered write, combinational read).
module ifetch_bht
  import ifetch_unit_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IDX_W-1:0]     lkup_idx,
  output logic [BHT_CNT_W-1:0] lkup_cnt,
  input  logic                 upd_valid,
  input  logic [IDX_W-1:0]     upd_idx,
  input  logic                 upd_taken
);

  localparam int N = 1 << IDX_W;

  logic [BHT_CNT_W-1:0] cnt_q [N];
  logic [BHT_CNT_W-1:0] cnt_cur;
  logic [BHT_CNT_W-1:0] cnt_d;

  assign lkup_cnt = cnt_q[lkup_idx];
  assign cnt_cur  = cnt_q[upd_idx];

  // Saturating increment on taken, decrement on not-taken.
  always_comb begin
    cnt_d = cnt_cur;
    if (upd_taken) begin
      if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'b01;
    end
  end

  // Counter storage; every entry returns to weakly not-taken on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= BHT_CNT_INIT;
    end else if (en && upd_valid) begin
      cnt_q[upd_idx] <= cnt_d;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage. Holds the fetch PC, presents it to the icache,
// predicts the next PC from the returned instruction and registers
// {inst, pc, pred_pc, pred_taken} for the decoder.
// Handshake: out_valid/out_ready are strict valid/ready; the output register
// is stable while out_valid && !out_ready, and a transfer happens on any
// edge with out_valid && out_ready (and rdy high).
// Build option IFETCH_BHT_EN: dynamic conditional-branch prediction via a
// counter table; otherwise backward-taken/forward-not-taken.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BHT_IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic [31:0] ic_pc,
  input  logic [31:0] ic_inst,
  input  logic        ic_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pred_pc,
  output logic        out_pred_taken,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  input  logic        bht_upd_valid,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] pred_q, pred_d;
  logic        taken_q, taken_d;

  logic        accept;
  logic        br_taken;
  logic [31:0] pred_pc;
  logic        pred_taken;

`ifdef IFETCH_BHT_EN
  logic [BHT_CNT_W-1:0] bht_cnt;
  logic [31:0]          unused_upd_pc;

  ifetch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .lkup_idx  (pc_q[BHT_IDX_W+1:2]),
    .lkup_cnt  (bht_cnt),
    .upd_valid (bht_upd_valid),
    .upd_idx   (bht_upd_pc[BHT_IDX_W+1:2]),
    .upd_taken (bht_upd_taken)
  );

  assign br_taken      = bht_cnt[1];
  assign unused_upd_pc = bht_upd_pc;
`else
  logic                 unused_bht;
  logic [BHT_IDX_W-1:0] unused_bht_idx;

  assign br_taken       = ic_inst[31];  // negative offset => backward
  assign unused_bht     = ^{bht_upd_valid, bht_upd_pc, bht_upd_taken};
  assign unused_bht_idx = pc_q[BHT_IDX_W+1:2];
`endif

  assign ic_pc          = pc_q;
  assign out_valid      = valid_q;
  assign out_inst       = inst_q;
  assign out_pc         = opc_q;
  assign out_pred_pc    = pred_q;
  assign out_pred_taken = taken_q;

  assign accept = ic_valid && (!valid_q || out_ready) && !flush_valid;

  // Next-PC prediction from the instruction returned for pc_q; JALR and
  // everything else falls through to pc+4 and relies on a backend flush.
  always_comb begin
    pred_pc    = pc_q + 32'd4;
    pred_taken = FALSE;
    case (ic_inst[6:0])
      OP_JAL: begin
        pred_pc    = pc_q + jal_imm(ic_inst);
        pred_taken = TRUE;
      end
      OP_BRANCH: begin
        if (br_taken) pred_pc = pc_q + br_imm(ic_inst);
        pred_taken = br_taken;
      end
      default: ;
    endcase
  end

  // Next-state: flush beats accept beats drain; rdy low freezes everything.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    pred_d  = pred_q;
    taken_d = taken_q;
    if (rdy) begin
      if (flush_valid) begin
        pc_d    = flush_pc;
        valid_d = FALSE;
      end else if (accept) begin
        pc_d    = pred_pc;
        valid_d = TRUE;
        inst_d  = ic_inst;
        opc_d   = pc_q;
        pred_d  = pred_pc;
        taken_d = pred_taken;
      end else if (valid_q && out_ready) begin
        valid_d = FALSE;
      end
    end
  end

  // Fetch PC and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= FALSE;
      inst_q  <= '0;
      opc_q   <= '0;
      pred_q  <= '0;
      taken_q <= FALSE;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      pred_q  <= pred_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed table-driven bench for ifetch_unit, plus hand sequences for
// BHT training, wrap-around and asynchronous reset during a stall.
// Build option IFETCH_BHT_EN changes the expected first prediction of a
// backward branch.
module tb_ifetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JAL20  = 32'h0200_006F;  // jal x0, +0x20
  localparam logic [31:0] BRFWD  = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] BRBACK = 32'hFE00_00E3;  // beq x0,x0,-32
  localparam logic [31:0] JALR   = 32'h0000_00E7;  // jalr x1,0(x0)

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] ic_pc;
  logic [31:0] ic_inst;
  logic        ic_valid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pred_pc;
  logic        out_pred_taken;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        bht_upd_valid;
  logic [31:0] bht_upd_pc;
  logic        bht_upd_taken;

  int n_checks = 0;
  int n_pass   = 0;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .ic_pc          (ic_pc),
    .ic_inst        (ic_inst),
    .ic_valid       (ic_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pred_pc    (out_pred_pc),
    .out_pred_taken (out_pred_taken),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .bht_upd_valid  (bht_upd_valid),
    .bht_upd_pc     (bht_upd_pc),
    .bht_upd_taken  (bht_upd_taken)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        iv;
    logic [31:0] inst;
    logic        ordy;
    logic        fv;
    logic [31:0] fpc;
    logic [31:0] e_icpc;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_pred;
    logic        e_tk;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] inst,
                              input logic ordy, input logic fv, input logic [31:0] fpc,
                              input logic [31:0] e_icpc, input logic e_ov,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic [31:0] e_pred, input logic e_tk);
    vec_t v;
    v.rdy = r; v.iv = iv; v.inst = inst; v.ordy = ordy; v.fv = fv; v.fpc = fpc;
    v.e_icpc = e_icpc; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_pred = e_pred; v.e_tk = e_tk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [31:0] icpc, input logic ov,
                           input logic [31:0] opc, input logic [31:0] oinst,
                           input logic [31:0] opred, input logic otk);
    check({tag, ".ic_pc"},          ic_pc,                  icpc);
    check({tag, ".out_valid"},      {31'd0, out_valid},     {31'd0, ov});
    check({tag, ".out_pc"},         out_pc,                 opc);
    check({tag, ".out_inst"},       out_inst,               oinst);
    check({tag, ".out_pred_pc"},    out_pred_pc,            opred);
    check({tag, ".out_pred_taken"}, {31'd0, out_pred_taken}, {31'd0, otk});
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; ic_valid = 1'b0; ic_inst = NOP; out_ready = 1'b1;
    flush_valid = 1'b0; flush_pc = '0;
    bht_upd_valid = 1'b0; bht_upd_pc = '0; bht_upd_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bt_pc;
  logic        bt_tk;

  initial begin
    idle_inputs();
    rst = 1'b0;

`ifdef IFETCH_BHT_EN
    bt_pc = 32'h44; bt_tk = 1'b0;  // untrained counter: weakly not-taken
`else
    bt_pc = 32'h20; bt_tk = 1'b1;  // backward branch statically taken
`endif

    //            rdy iv inst    ordy fv fpc            ic_pc       ov out_pc        inst    pred          tk
    vecs[0]  = mk(1, 1, NOP,    1, 0, 0,             32'h4,      1, 32'h0,        NOP,    32'h4,        0);
    vecs[1]  = mk(1, 1, NOP,    1, 0, 0,             32'h8,      1, 32'h4,        NOP,    32'h8,        0);
    vecs[2]  = mk(1, 1, NOP,    1, 0, 0,             32'hC,      1, 32'h8,        NOP,    32'hC,        0);
    vecs[3]  = mk(1, 1, NOP,    1, 0, 0,             32'h10,     1, 32'hC,        NOP,    32'h10,       0);
    vecs[4]  = mk(1, 1, JAL20,  1, 0, 0,             32'h30,     1, 32'h10,       JAL20,  32'h30,       1);
    vecs[5]  = mk(1, 1, NOP,    0, 0, 0,             32'h30,     1, 32'h10,       JAL20,  32'h30,       1);
    vecs[6]  = mk(1, 1, NOP,    0, 0, 0,             32'h30,     1, 32'h10,       JAL20,  32'h30,       1);
    vecs[7]  = mk(1, 1, NOP,    0, 0, 0,             32'h30,     1, 32'h10,       JAL20,  32'h30,       1);
    vecs[8]  = mk(1, 1, NOP,    1, 0, 0,             32'h34,     1, 32'h30,       NOP,    32'h34,       0);
    vecs[9]  = mk(1, 0, NOP,    1, 0, 0,             32'h34,     0, 32'h30,       NOP,    32'h34,       0);
    vecs[10] = mk(1, 1, NOP,    1, 1, 32'h100,       32'h100,    0, 32'h30,       NOP,    32'h34,       0);
    vecs[11] = mk(1, 1, BRFWD,  1, 0, 0,             32'h104,    1, 32'h100,      BRFWD,  32'h104,      0);
    vecs[12] = mk(1, 0, NOP,    1, 1, 32'h40,        32'h40,     0, 32'h100,      BRFWD,  32'h104,      0);
    vecs[13] = mk(1, 1, BRBACK, 1, 0, 0,             bt_pc,      1, 32'h40,       BRBACK, bt_pc,        bt_tk);
    vecs[14] = mk(0, 1, NOP,    1, 1, 32'h200,       bt_pc,      1, 32'h40,       BRBACK, bt_pc,        bt_tk);
    vecs[15] = mk(1, 1, JALR,   1, 0, 0,             bt_pc + 4,  1, bt_pc,        JALR,   bt_pc + 4,    0);
    vecs[16] = mk(1, 0, NOP,    1, 1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, bt_pc,     JALR,   bt_pc + 4,    0);
    vecs[17] = mk(1, 1, JAL20,  1, 0, 0,             32'h10,     1, 32'hFFFF_FFF0, JAL20, 32'h10,       1);

    // Reset state
    #12;
    check_all("reset", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    #2;

    for (int i = 0; i < NV; i++) begin
      rdy = vecs[i].rdy; ic_valid = vecs[i].iv; ic_inst = vecs[i].inst;
      out_ready = vecs[i].ordy; flush_valid = vecs[i].fv; flush_pc = vecs[i].fpc;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_icpc, vecs[i].e_ov, vecs[i].e_pc,
                vecs[i].e_inst, vecs[i].e_pred, vecs[i].e_tk);
    end

    // Train branch at 0x40 taken twice, then refetch it.
    idle_inputs();
    bht_upd_valid = 1'b1; bht_upd_pc = 32'h40; bht_upd_taken = 1'b1;
    step();
    step();
    bht_upd_valid = 1'b0;
    flush_valid = 1'b1; flush_pc = 32'h40;
    step();
    check("train.flush_ic_pc", ic_pc, 32'h40);
    check("train.flush_ov", {31'd0, out_valid}, 32'd0);
    flush_valid = 1'b0;
    ic_valid = 1'b1; ic_inst = BRBACK;
    step();
    check_all("trained", 32'h20, 1, 32'h40, BRBACK, 32'h20, 1);

    // Stall, then drop reset asynchronously between clock edges.
    ic_inst = NOP; out_ready = 1'b0;
    step();
    check_all("stall", 32'h20, 1, 32'h40, BRBACK, 32'h20, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
    step();
    check_all("rst_held", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);

    // After reset the counter is weak again: branch at 0x40 predicts as untrained.
    idle_inputs();
    rst = 1'b1;
    flush_valid = 1'b1; flush_pc = 32'h40;
    step();
    flush_valid = 1'b0;
    ic_valid = 1'b1; ic_inst = BRBACK;
    step();
    check_all("post_rst_br", bt_pc, 1, 32'h40, BRBACK, bt_pc, bt_tk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage; sits directly downstream of the instruction cache and upstream of the decoder/instruction queue.
- Holds the architectural fetch PC and presents it to the icache every cycle.
- Accepts the returned instruction, predicts the next PC, and hands {inst, pc, predicted next pc} downstream over a valid/ready handshake.
- Redirects on backend flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- BHT_IDX_W, 8, log2 of BHT entries; BHT indexed by pc[BHT_IDX_W+1:2] (used only with IFETCH_BHT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when low, all state frozen.
- ic_pc  out  32  fetch address to icache; combinational copy of the pc register, always valid.
- ic_inst  in  32  instruction from icache.
- ic_valid  in  1  ic_inst valid for the current ic_pc this cycle.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_inst  out  32  fetched instruction.
- out_pc  out  32  its address.
- out_pred_pc  out  32  predicted next pc.
- out_pred_taken  out  1  prediction taken flag.
- flush_valid  in  1  backend redirect.
- flush_pc  in  32  redirect target.
- bht_upd_valid  in  1  resolved conditional branch.
- bht_upd_pc  in  32  resolved branch pc.
- bht_upd_taken  in  1  actual outcome.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC; out_valid=0; out_inst=0; out_pc=0; out_pred_pc=0; out_pred_taken=0; all BHT counters = 2'b01 (weakly not-taken).
- rdy=0: no register changes; handshake ignored.
- accept = ic_valid && (!out_valid || out_ready) && !flush_valid.
- On accept (registered, 1-cycle latency): out_inst=ic_inst; out_pc=pc; out_pred_pc/out_pred_taken=prediction; out_valid=1; pc=pred_pc.
- If out_valid && out_ready && !accept: out_valid=0.
- Output held stable while out_valid && !out_ready; pc does not advance; ic_valid is ignored (icache re-presents on hit).
- Flush has priority over everything:
  - pc=flush_pc; out_valid=0.
  - An ic_valid in the same cycle is dropped.
  - Any in-flight icache miss for the old pc is abandoned; the icache gates its valid on address match, so the stale fill never produces ic_valid.
- Prediction (combinational on ic_inst):
  - opcode 1101111 (JAL): taken; target = pc + sext(imm[20:1],0).
  - opcode 1100011 (branch): target = pc + sext(imm[12:1],0); taken per the optional feature.
  - All others, including JALR: pc+4, not taken; the backend flushes on JALR.
  - 32-bit wrap-around on all additions; no overflow detection.
- Simultaneous accept and out_ready: new instruction replaces old in the same edge; sustains 1 inst/cycle on icache hits.
- bht_upd and a lookup of the same index in the same cycle: lookup sees the old counter.

Optional Feature:
- Macro: IFETCH_BHT_EN.
- Defined:
  - Conditional branches use a 2^BHT_IDX_W-entry 2-bit saturating counter table; taken iff counter[1].
  - On bht_upd_valid, the counter at bht_upd_pc[BHT_IDX_W+1:2] increments (taken) or decrements, saturating at 3/0.
- Undefined:
  - Static prediction: backward branch (imm sign=1) taken, forward not taken.
  - bht_upd_* ports remain present and are ignored; no table storage.

Decomposition:
- Shared defines package: True/False, opcode constants (OP_JAL, OP_BRANCH, OP_JALR), RESET_PC default, BHT counter width/init value.
- One sub-module: ifetch_bht (counter table with lookup index, update port, async-low reset), instantiated only under IFETCH_BHT_EN.

Test Plan:
- Reset then ic_valid=1 with NOPs (32'h00000013) every cycle, out_ready=1 -> ic_pc sequence 0,4,8,...; out_pc lags one cycle; one inst per cycle.
- At pc=0x10 return JAL imm=+0x20 (32'h0200006F) -> out_pred_taken=1, out_pred_pc=0x30, next ic_pc=0x30.
- Hold out_ready=0 for 3 cycles with ic_valid=1 -> out_* stable, ic_pc stable; release -> fetch resumes with no drop or duplicate.
- flush_valid=1, flush_pc=0x100 in the same cycle as ic_valid=1 -> out_valid=0 next cycle, that inst dropped, ic_pc=0x100.
- With IFETCH_BHT_EN: branch at 0x40 with target 0x20, two bht_upd taken -> next fetch of 0x40 predicts 0x20. Without the macro: same branch predicts 0x20 (backward) at the first fetch.
- Assert rst low mid-stall -> all outputs zero and ic_pc=RESET_PC immediately, without waiting for a clock edge.
